// File: rtl/equiv_mismatch_monitor.sv
// Equivalence mismatch monitor: compares two result buses once a post-reset settle window has
// elapsed. It keeps sticky status, a saturating count and a first-mismatch record, and streams
// every counted mismatch through a small show-ahead FIFO to a valid/ready log sink.
module equiv_mismatch_monitor #(
  parameter int unsigned WIDTH  = 91,
  parameter int unsigned SETTLE = 4,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned CYC_W  = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             clear,
  input  logic [WIDTH-1:0] y_1,
  input  logic [WIDTH-1:0] y_2,
  output logic             mismatch,
  output logic             fail,
  output logic [CNT_W-1:0] mismatch_count,
  output logic             first_valid,
  output logic [CYC_W-1:0] first_cycle,
  output logic [WIDTH-1:0] first_diff,
  output logic             overflow,
  output logic             log_valid,
  input  logic             log_ready,
  output logic [CYC_W-1:0] log_cycle,
  output logic [WIDTH-1:0] log_diff
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OccW = PtrW + 1;
  localparam int unsigned SetW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SetW-1:0] SettleLast = SetW'((SETTLE == 0) ? 0 : SETTLE - 1);
  localparam logic [OccW-1:0] OccFull = OccW'(DEPTH);

  typedef enum logic [0:0] {StSettle, StRun} state_e;
  // With no settle window the monitor compares from the very first enabled cycle.
  localparam state_e StInit = (SETTLE == 0) ? StRun : StSettle;

  state_e            state_q, state_d;
  logic [SetW-1:0]   settle_cnt_q, settle_cnt_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic              mismatch_q, mismatch_d;
  logic              fail_q, fail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              first_valid_q, first_valid_d;
  logic [CYC_W-1:0]  first_cycle_q, first_cycle_d;
  logic [WIDTH-1:0]  first_diff_q, first_diff_d;
  logic              overflow_q, overflow_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [OccW-1:0]   occ_q, occ_d;
  logic [CYC_W-1:0]  mem_cyc_q  [DEPTH];
  logic [WIDTH-1:0]  mem_diff_q [DEPTH];

  logic [WIDTH-1:0]  diff;
  logic              hit, pop, full, push_ok;

  assign diff    = y_1 ^ y_2;
  assign hit     = enable && (state_q == StRun) && (|diff);
  assign pop     = log_valid && log_ready;
  assign full    = (occ_q == OccFull);
  // A push into a full FIFO survives only when the head leaves in the same cycle.
  assign push_ok = hit && (!full || pop);

  // FSM next state: count enabled cycles in the settle window, then stay in RUN.
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    if (clear) begin
      state_d      = StInit;
      settle_cnt_d = '0;
    end else if (state_q == StSettle && enable) begin
      if (settle_cnt_q == SettleLast) begin
        state_d = StRun;
      end else begin
        settle_cnt_d = settle_cnt_q + SetW'(1);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StInit;
      settle_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
    end
  end

  // Status, first-mismatch capture and FIFO bookkeeping next state; clear wins over everything.
  always_comb begin
    cyc_d         = cyc_q;
    mismatch_d    = 1'b0;
    fail_d        = fail_q;
    count_d       = count_q;
    first_valid_d = first_valid_q;
    first_cycle_d = first_cycle_q;
    first_diff_d  = first_diff_q;
    overflow_d    = overflow_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    occ_d         = occ_q;
    if (clear) begin
      cyc_d         = '0;
      fail_d        = 1'b0;
      count_d       = '0;
      first_valid_d = 1'b0;
      first_cycle_d = '0;
      first_diff_d  = '0;
      overflow_d    = 1'b0;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      occ_d         = '0;
    end else begin
      if (enable && cyc_q != '1) begin
        cyc_d = cyc_q + CYC_W'(1);
      end
      if (hit) begin
        mismatch_d = 1'b1;
        fail_d     = 1'b1;
        if (count_q != '1) begin
          count_d = count_q + CNT_W'(1);
        end
        if (!first_valid_q) begin
          first_valid_d = 1'b1;
          first_cycle_d = cyc_q;
          first_diff_d  = diff;
        end
        if (!push_ok) begin
          overflow_d = 1'b1;
        end
      end
      if (push_ok) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      unique case ({push_ok, pop})
        2'b10:   occ_d = occ_q + OccW'(1);
        2'b01:   occ_d = occ_q - OccW'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  // Status and FIFO control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q         <= '0;
      mismatch_q    <= 1'b0;
      fail_q        <= 1'b0;
      count_q       <= '0;
      first_valid_q <= 1'b0;
      first_cycle_q <= '0;
      first_diff_q  <= '0;
      overflow_q    <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      occ_q         <= '0;
    end else begin
      cyc_q         <= cyc_d;
      mismatch_q    <= mismatch_d;
      fail_q        <= fail_d;
      count_q       <= count_d;
      first_valid_q <= first_valid_d;
      first_cycle_q <= first_cycle_d;
      first_diff_q  <= first_diff_d;
      overflow_q    <= overflow_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      occ_q         <= occ_d;
    end
  end

  // FIFO storage; no reset needed since reads are masked while empty.
  always_ff @(posedge clk) begin
    if (push_ok && !clear) begin
      mem_cyc_q[wr_ptr_q]  <= cyc_q;
      mem_diff_q[wr_ptr_q] <= diff;
    end
  end

  assign mismatch       = mismatch_q;
  assign fail           = fail_q;
  assign mismatch_count = count_q;
  assign first_valid    = first_valid_q;
  assign first_cycle    = first_cycle_q;
  assign first_diff     = first_diff_q;
  assign overflow       = overflow_q;
  assign log_valid      = (occ_q != '0);
  // Head is forced to zero while empty so outputs read as zero after reset/clear.
  assign log_cycle      = log_valid ? mem_cyc_q[rd_ptr_q] : '0;
  assign log_diff       = log_valid ? mem_diff_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_equiv_mismatch_monitor.sv
// Bench for equiv_mismatch_monitor: directed vectors, log entries checked by a scoreboard.
module tb_equiv_mismatch_monitor;

  localparam int unsigned W  = 91;
  localparam int unsigned CW = 32;

  logic          clk = 1'b0;
  logic          rst_n, enable, clear, log_ready;
  logic [W-1:0]  y_1, y_2;

  logic          mismatch, fail, first_valid, overflow, log_valid;
  logic [15:0]   mismatch_count;
  logic [CW-1:0] first_cycle, log_cycle;
  logic [W-1:0]  first_diff, log_diff;

  logic          s_mismatch, s_fail, s_first_valid, s_overflow, s_log_valid;
  logic [3:0]    s_count;
  logic [CW-1:0] s_first_cycle, s_log_cycle;
  logic [W-1:0]  s_first_diff, s_log_diff;

  equiv_mismatch_monitor u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear), .y_1(y_1), .y_2(y_2),
    .mismatch(mismatch), .fail(fail), .mismatch_count(mismatch_count),
    .first_valid(first_valid), .first_cycle(first_cycle), .first_diff(first_diff),
    .overflow(overflow), .log_valid(log_valid), .log_ready(log_ready),
    .log_cycle(log_cycle), .log_diff(log_diff)
  );

  // Narrow counter instance for saturation.
  equiv_mismatch_monitor #(.CNT_W(4)) u_small (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear), .y_1(y_1), .y_2(y_2),
    .mismatch(s_mismatch), .fail(s_fail), .mismatch_count(s_count),
    .first_valid(s_first_valid), .first_cycle(s_first_cycle), .first_diff(s_first_diff),
    .overflow(s_overflow), .log_valid(s_log_valid), .log_ready(log_ready),
    .log_cycle(s_log_cycle), .log_diff(s_log_diff)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CW-1:0] cyc;
    logic [W-1:0]  diff;
  } ent_t;

  ent_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   pops   = 0;
  int   p0     = 0;

  localparam logic [W-1:0] Base = {27'h5A5A5A5, 64'h0123_4567_89AB_CDEF};

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int c, input logic [W-1:0] d);
    ent_t e;
    e.cyc  = CW'(c);
    e.diff = d;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc_in(input logic en, input logic [W-1:0] d);
    enable = en;
    y_1    = Base;
    y_2    = Base ^ d;
    tick();
  endtask

  task automatic do_clear();
    clear  = 1'b1;
    enable = 1'b0;
    tick();
    clear  = 1'b0;
  endtask

  // Monitor: every accepted log head is compared against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && log_valid && log_ready) begin
      pops++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL log_unexpected: got {%0d,%0h} expected none", log_cycle, log_diff);
      end else begin
        ent_t e;
        e = exp_q.pop_front();
        check("log_cycle", 128'(log_cycle), 128'(e.cyc));
        check("log_diff", 128'(log_diff), 128'(e.diff));
      end
    end
  end

  initial begin
    rst_n = 1'b0; enable = 1'b0; clear = 1'b0; log_ready = 1'b0;
    y_1 = Base; y_2 = Base;
    #12 rst_n = 1'b1;
    check("rst_mismatch", 128'(mismatch), 128'(0));
    check("rst_fail", 128'(fail), 128'(0));
    check("rst_count", 128'(mismatch_count), 128'(0));
    check("rst_first_valid", 128'(first_valid), 128'(0));
    check("rst_overflow", 128'(overflow), 128'(0));
    check("rst_log_valid", 128'(log_valid), 128'(0));

    // T1: equal results for 100 cycles.
    for (int i = 0; i < 100; i++) begin
      enable = 1'b1;
      y_1    = {27'(i), 64'(i * 32'h9E37_79B9)};
      y_2    = y_1;
      tick();
    end
    check("t1_fail", 128'(fail), 128'(0));
    check("t1_count", 128'(mismatch_count), 128'(0));
    check("t1_log_valid", 128'(log_valid), 128'(0));
    check("t1_first_valid", 128'(first_valid), 128'(0));

    // T2: settle-window hits ignored, single hit at cycle 10.
    do_clear();
    for (int c = 0; c < 16; c++) begin
      if (c == 10) push_exp(c, W'(1));
      cyc_in(1'b1, (c < 4 || c == 10) ? W'(1) : '0);
      if (c == 3) check("t2_settle_mismatch", 128'(mismatch), 128'(0));
      if (c == 3) check("t2_settle_count", 128'(mismatch_count), 128'(0));
      if (c == 10) check("t2_mismatch", 128'(mismatch), 128'(1));
      if (c == 11) check("t2_mismatch_drop", 128'(mismatch), 128'(0));
    end
    enable = 1'b0;
    check("t2_fail", 128'(fail), 128'(1));
    check("t2_count", 128'(mismatch_count), 128'(1));
    check("t2_first_valid", 128'(first_valid), 128'(1));
    check("t2_first_cycle", 128'(first_cycle), 128'(10));
    check("t2_first_diff", 128'(first_diff), 128'(1));
    check("t2_head_valid", 128'(log_valid), 128'(1));
    check("t2_head_cycle", 128'(log_cycle), 128'(10));
    check("t2_head_diff", 128'(log_diff), 128'(1));
    log_ready = 1'b1;
    tick();
    log_ready = 1'b0;
    check("t2_drained", 128'(log_valid), 128'(0));

    // T3: six hits with sink stalled -> four kept, overflow.
    do_clear();
    for (int c = 0; c < 16; c++) begin
      if (c >= 5 && c <= 8) push_exp(c, W'(c));
      cyc_in(1'b1, (c >= 5 && c <= 10) ? W'(c) : '0);
    end
    enable = 1'b0;
    check("t3_count", 128'(mismatch_count), 128'(6));
    check("t3_overflow", 128'(overflow), 128'(1));
    check("t3_first_cycle", 128'(first_cycle), 128'(5));
    check("t3_first_diff", 128'(first_diff), 128'(5));
    log_ready = 1'b1;
    repeat (6) tick();
    log_ready = 1'b0;
    check("t3_empty", 128'(log_valid), 128'(0));
    check("t3_sb_empty", 128'(exp_q.size()), 128'(0));

    // T4: full FIFO with simultaneous pop and push.
    do_clear();
    for (int c = 0; c < 8; c++) begin
      if (c >= 4) push_exp(c, W'(c + 256));
      cyc_in(1'b1, (c >= 4) ? W'(c + 256) : '0);
    end
    check("t4_full_overflow", 128'(overflow), 128'(0));
    log_ready = 1'b1;
    push_exp(8, W'(8 + 256));
    cyc_in(1'b1, W'(8 + 256));
    check("t4_overflow", 128'(overflow), 128'(0));
    enable = 1'b0;
    p0 = pops;
    repeat (6) tick();
    check("t4_occupancy", 128'(pops - p0), 128'(4));
    check("t4_empty", 128'(log_valid), 128'(0));
    check("t4_count", 128'(mismatch_count), 128'(5));

    // T5: 20 consecutive hits, narrow counter saturates at 15.
    do_clear();
    log_ready = 1'b1;
    for (int c = 0; c < 24; c++) begin
      if (c >= 4) push_exp(c, W'(c * 3 + 1));
      cyc_in(1'b1, (c >= 4) ? W'(c * 3 + 1) : '0);
      if (c == 18) check("t5_small_at15", 128'(s_count), 128'(15));
    end
    enable = 1'b0;
    check("t5_small_count", 128'(s_count), 128'(15));
    check("t5_count", 128'(mismatch_count), 128'(20));
    check("t5_small_first_cycle", 128'(s_first_cycle), 128'(4));
    check("t5_small_first_diff", 128'(s_first_diff), 128'(13));
    check("t5_small_fail", 128'(s_fail), 128'(1));
    repeat (2) tick();
    check("t5_sb_empty", 128'(exp_q.size()), 128'(0));

    // T6: async reset mid-cycle, then clear with a simultaneous hit.
    log_ready = 1'b0;
    cyc_in(1'b1, W'(7));
    cyc_in(1'b1, W'(7));
    enable = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("t6_mismatch", 128'(mismatch), 128'(0));
    check("t6_fail", 128'(fail), 128'(0));
    check("t6_count", 128'(mismatch_count), 128'(0));
    check("t6_first_valid", 128'(first_valid), 128'(0));
    check("t6_first_cycle", 128'(first_cycle), 128'(0));
    check("t6_first_diff", 128'(first_diff), 128'(0));
    check("t6_overflow", 128'(overflow), 128'(0));
    check("t6_log_valid", 128'(log_valid), 128'(0));
    check("t6_log_cycle", 128'(log_cycle), 128'(0));
    check("t6_log_diff", 128'(log_diff), 128'(0));
    #2 rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      cyc_in(1'b1, W'(c + 1));
      if (c == 3) check("t6_resettle_count", 128'(mismatch_count), 128'(0));
      if (c == 4) check("t6_run_count", 128'(mismatch_count), 128'(1));
      if (c == 4) check("t6_run_first_cycle", 128'(first_cycle), 128'(4));
    end
    clear = 1'b1;
    cyc_in(1'b1, W'(9));
    clear  = 1'b0;
    enable = 1'b0;
    check("t6_clr_mismatch", 128'(mismatch), 128'(0));
    check("t6_clr_fail", 128'(fail), 128'(0));
    check("t6_clr_count", 128'(mismatch_count), 128'(0));
    check("t6_clr_first_valid", 128'(first_valid), 128'(0));
    check("t6_clr_log_valid", 128'(log_valid), 128'(0));
    log_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c == 4) push_exp(c, W'(c + 1));
      cyc_in(1'b1, W'(c + 1));
      if (c == 3) check("t6_clr_settle_count", 128'(mismatch_count), 128'(0));
      if (c == 4) check("t6_clr_first_cycle", 128'(first_cycle), 128'(4));
    end
    enable = 1'b0;
    repeat (2) tick();
    check("t6_sb_empty", 128'(exp_q.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
